// File: rtl/sqrt_control.sv
// sqrt_control: sequencing controller for the iterative square-root datapath.
// Issues start -> NITER calc cycles (step counts NITER-1 down to 0) -> stop -> done.
// Every output is a flop decoded from the next state, so there is no input-to-output path.
module sqrt_control #(
    parameter int unsigned NITER = 16,
    parameter int unsigned CW    = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          abort,
    output logic          start,
    output logic          calc,
    output logic [CW-1:0] step,
    output logic          stop,
    output logic          done,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CALC  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_LOAD = CW'(NITER - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_q, start_d;
    logic          calc_q, calc_d;
    logic [CW-1:0] step_q, step_d;
    logic          stop_q, stop_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Next-state and iteration-counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run && !abort) state_d = S_START;
            end
            S_START: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_CALC;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_CALC: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (run && !abort) state_d = S_START;
                else               state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so each strobe is registered and aligned with its state
    always_comb begin
        start_d = (state_d == S_START);
        calc_d  = (state_d == S_CALC);
        step_d  = (state_d == S_CALC) ? cnt_d : '0;
        stop_d  = (state_d == S_STOP);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d == S_START) || (state_d == S_CALC) || (state_d == S_STOP);
    end

    // State, counter and output registers with immediate reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            calc_q  <= 1'b0;
            step_q  <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            calc_q  <= calc_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign start = start_q;
    assign calc  = calc_q;
    assign step  = step_q;
    assign stop  = stop_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sqrt_control.sv
// Directed bench for sqrt_control: NITER=16 instance plus an NITER=1 instance.
// Outputs are packed as {start, calc, step[7:0], stop, done, busy} and checked at the falling edge.
module tb_sqrt_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic abort = 1'b0;
    logic run1 = 1'b0;
    logic abort1 = 1'b0;

    logic       start, calc, stop, done, busy;
    logic [7:0] step;
    logic       start1, calc1, stop1, done1, busy1;
    logic [7:0] step1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run;
        logic        abort;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[24];

    sqrt_control #(.NITER(16), .CW(8)) dut (
        .clock(clk), .reset(rst), .run(run), .abort(abort),
        .start(start), .calc(calc), .step(step), .stop(stop), .done(done), .busy(busy)
    );

    sqrt_control #(.NITER(1), .CW(8)) dut1 (
        .clock(clk), .reset(rst), .run(run1), .abort(abort1),
        .start(start1), .calc(calc1), .step(step1), .stop(stop1), .done(done1), .busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs16();
        return {start, calc, step, stop, done, busy};
    endfunction

    function automatic logic [12:0] obs1();
        return {start1, calc1, step1, stop1, done1, busy1};
    endfunction

    // Expected outputs in cycle c for an operation whose run was sampled at the end of cycle base
    function automatic logic [12:0] ex(int c, int base, int n);
        int k;
        k = c - base;
        if (k == 1)                   return {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        if (k >= 2 && k <= n + 1)     return {1'b0, 1'b1, 8'(n + 1 - k), 1'b0, 1'b0, 1'b1};
        if (k == n + 2)               return {1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
        if (k == n + 3)               return {1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        return 13'd0;
    endfunction

    task automatic chk(input string nm, input int c, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got {start,calc,step,stop,done,busy}=%b_%b_%h_%b_%b_%b expected %b_%b_%h_%b_%b_%b",
                     nm, c, act[12], act[11], act[10:3], act[2], act[1], act[0],
                     exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // Table: single root with ignored run pulses at cycles 5 (CALC) and 18 (STOP)
        for (int c = 0; c < 24; c++) begin
            tbl[c].run   = (c == 0) || (c == 5) || (c == 18);
            tbl[c].abort = 1'b0;
            tbl[c].exp   = ex(c, 0, 16);
        end

        // Asynchronous reset asserted mid-cycle: outputs clear without a clock edge
        #12 rst = 1'b1;
        #1;
        chk("reset_async16", 0, obs16(), 13'd0);
        chk("reset_async1", 0, obs1(), 13'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            chk("single_root", c, obs16(), tbl[c].exp);
            run   = tbl[c].run;
            abort = tbl[c].abort;
        end
        run = 1'b0;

        // Back-to-back with run held high: starts at 1, 20, 39
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk("back_to_back", c, obs16(), ex(c, 0, 16) | ex(c, 19, 16) | ex(c, 38, 16));
            run = (c <= 40);
        end
        run = 1'b0;

        // Abort mid-CALC at cycle 9, new run at cycle 12
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            chk("abort_calc", c, obs16(), (c <= 9) ? ex(c, 0, 16) : ex(c, 12, 16));
            run   = (c == 0) || (c == 12);
            abort = (c == 9);
        end
        run   = 1'b0;
        abort = 1'b0;

        // abort and run together in IDLE: no start
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("abort_run_idle", c, obs16(), 13'd0);
            run   = (c == 0);
            abort = (c == 0);
        end
        run   = 1'b0;
        abort = 1'b0;

        // Asynchronous reset during CALC at cycle 7, then a full new operation
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            chk("reset_calc", c, obs16(), (c <= 7) ? ex(c, 0, 16) : ex(c, 12, 16));
            run = (c == 0) || (c == 12);
            if (c == 7) begin
                #2 rst = 1'b1;
                #1;
                chk("reset_calc_async", c, obs16(), 13'd0);
                #1 rst = 1'b0;
            end
        end
        run = 1'b0;

        // NITER=1 instance: start@1, calc@2 step 0, stop@3, done@4
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("niter1", c, obs1(), ex(c, 0, 1));
            run1 = (c == 0);
        end
        run1 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_control.md
# sqrt_control

Sequencing controller for the iterative 32-bit square-root datapath (`sqrt_datapath`). It accepts a one-cycle `run` request from the host logic. It then drives the datapath's `start` (operand load), per-iteration enable and bit index, and `stop` (result register load) strobes. Finally it reports completion with a `done` pulse. It sits between the host/top-level FSM and the datapath and owns all datapath timing.

## Interface
- `NITER`, 16, number of iterations per root (legal 1..255; 16 for a 32-bit operand).
- `CW`, 8, width of the iteration counter and `step` output; must satisfy 2^CW > NITER-1.

- `clock`  in  1  master clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  start request, sampled on the rising edge of `clock`.
- `abort`  in  1  cancel the operation in progress.
- `start`  out  1  one-cycle strobe: datapath loads `xin`.
- `calc`  out  1  datapath iteration enable.
- `step`  out  CW  current bit index during CALC.
- `stop`  out  1  one-cycle strobe: datapath loads its output register.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from START through STOP inclusive.

## Operation
- FSM states: IDLE, START, CALC, STOP, DONE. All outputs are registered and decoded from the registered state, with no combinational input-to-output path.
- IDLE:
  - `run`=1 and `abort`=0 -> START.
  - Otherwise stay in IDLE.
- START:
  - `start`=1 and `busy`=1.
  - Counter loads NITER-1.
  - -> CALC unconditionally, unless aborted.
- CALC:
  - `calc`=1 and `busy`=1; `step` equals the counter.
  - The counter decrements once per cycle.
  - When the counter is 0, go to STOP. CALC therefore lasts exactly NITER cycles.
- STOP: `stop`=1 and `busy`=1; -> DONE.
- DONE:
  - `done`=1 and `busy`=0.
  - `run`=1 -> START (back-to-back accepted).
  - Otherwise -> IDLE.
- `abort`=1 in START, CALC or STOP:
  - Next state is IDLE; `stop` and `done` are not issued for that operation.
  - The counter is cleared to 0.
- `abort`=1 in IDLE or DONE: ignored for state purposes. If `run` is asserted in the same cycle, `abort` wins and `run` is dropped.
- `run` in START, CALC or STOP: ignored, not queued; the operation in progress is unaffected.
- Outputs outside their states:
  - `step` = 0 outside CALC.
  - `start`, `calc`, `stop` and `done` = 0 outside their own states.
- Counter arithmetic is unsigned CW-bit. It never decrements below 0, so no wrap-around can occur.

## Timing
- Reset (asynchronous, immediate): state IDLE, counter 0, and all outputs 0 (`start`, `calc`, `step`, `stop`, `done`, `busy`).
- When reset is released, the FSM is in IDLE and accepts `run` on the first rising edge where `reset` is low.
- Reset asserted mid-operation forces IDLE immediately. No `stop` and no `done` are issued.
- Cycle numbering: `run` is sampled high at the edge that ends cycle 0.
  - cycle 1: `start`
  - cycles 2..NITER+1: `calc`, with `step` = NITER-1 down to 0
  - cycle NITER+2: `stop`
  - cycle NITER+3: `done`
- Request-to-`done` latency is NITER+3 cycles. Back-to-back throughput is one root per NITER+3 cycles (`run` held or pulsed during DONE).
- `busy` is high in cycles 1..NITER+2. It is low in DONE, so hosts may issue the next `run` when `busy`=0.
- NITER=1: CALC lasts one cycle with `step`=0, and latency is 4 cycles.

## Test plan
- Reset and single root (NITER=16):
  - Stimulus: assert `reset` asynchronously mid-cycle, then release it and pulse `run` at cycle 0.
  - Response: all outputs are 0 immediately on reset. After the `run` pulse, `start`@1, `calc`@2..17 with `step` 15..0, `stop`@18, `done`@19, and `busy` high during 1..18 only.
- Back-to-back:
  - Stimulus: hold `run`=1 continuously.
  - Response: `start` pulses every 19 cycles (at 1, 20, 39). `done` pulses at 19, 38. `stop` precedes each `done` by exactly 1 cycle.
- Abort mid-CALC:
  - Stimulus: `abort`=1 at cycle 9.
  - Response: IDLE at cycle 10 with all outputs 0. No `stop`/`done` follow. A new `run` at cycle 12 gives `start` at 13.
- Ignored requests:
  - Stimulus: pulse `run` at cycles 5 and 18 during an operation; also `abort`+`run` together in IDLE.
  - Response: the timing of the first operation is unchanged and no extra `start` appears. In the `abort`+`run` case, no `start` is issued.
- Asynchronous reset mid-CALC:
  - Stimulus: `reset` pulse between clock edges at cycle 7.
  - Response: `calc`/`busy` drop without waiting for a clock edge. No `stop`/`done` follow. The next `run` proceeds with full 16-step timing.
- NITER=1 instance:
  - Stimulus: `run` at cycle 0.
  - Response: `start`@1, `calc`@2 with `step`=0, `stop`@3, `done`@4.
